// File: rtl/seg_msg_decoder_if.sv
// Bundles the segment-link inputs and the decoder status outputs between a
// stimulus/host side (master) and the decoder (slave).
interface seg_msg_decoder_if #(
    parameter int CNT_W = 8
);
    logic             ena;
    logic [7:0]       seg_in;
    logic             seg_stb;
    logic             sym_valid;
    logic [3:0]       sym_code;
    logic             match;
    logic [3:0]       pos;
    logic             msg_done;
    logic             err;
    logic [CNT_W-1:0] msg_count;

    modport master (
        output ena, seg_in, seg_stb,
        input  sym_valid, sym_code, match, pos, msg_done, err, msg_count
    );

    modport slave (
        input  ena, seg_in, seg_stb,
        output sym_valid, sym_code, match, pos, msg_done, err, msg_count
    );
endinterface

// File: rtl/seg_msg_decoder.sv
// Receive end of the 7-segment message link: synchronises the strobe, decodes
// each segment byte and tracks it against the fixed 14-symbol message.
module seg_msg_decoder #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    seg_msg_decoder_if.slave  bus
);
    typedef enum logic {HUNT, TRACK} state_t;

    localparam logic [3:0] LAST_POS = 4'd13;

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   prev_reg;
    logic                   stb_edge;

    state_t           state_reg, state_next;
    logic [3:0]       pos_reg, pos_next;
    logic             err_reg, err_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             sym_valid_reg, sym_valid_next;
    logic             done_reg, done_next;
    logic [3:0]       code_reg, code_next;
    logic             match_reg, match_next;
    logic [3:0]       dec_code;
    logic [3:0]       exp_code;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_reg[0] <= 1'b0;
            prev_reg    <= 1'b0;
        end else begin
            sync_reg[0] <= bus.seg_stb;
            prev_reg    <= sync_reg[SYNC_STAGES-1];
        end
    end

    generate
        for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
            always_ff @(posedge clk) begin
                if (!rst_n) sync_reg[gi] <= 1'b0;
                else        sync_reg[gi] <= sync_reg[gi-1];
            end
        end
    endgenerate

    // Sync chain keeps running while disabled so no stale edge appears on re-enable.
    assign stb_edge = sync_reg[SYNC_STAGES-1] & ~prev_reg & bus.ena;

    always_comb begin
        case (bus.seg_in)
            8'h5B:   dec_code = 4'h1;
            8'h4F:   dec_code = 4'h2;
            8'h15:   dec_code = 4'h3;
            8'h7E:   dec_code = 4'h4;
            8'h0E:   dec_code = 4'h5;
            8'h5F:   dec_code = 4'h6;
            8'h3E:   dec_code = 4'h7;
            8'h80:   dec_code = 4'h8;
            8'h00:   dec_code = 4'h0;
            default: dec_code = 4'hF;
        endcase
    end

    always_comb begin
        case (pos_reg)
            4'd0:    exp_code = 4'h1;
            4'd1:    exp_code = 4'h2;
            4'd2:    exp_code = 4'h3;
            4'd3:    exp_code = 4'h4;
            4'd4:    exp_code = 4'h5;
            4'd5:    exp_code = 4'h6;
            4'd6:    exp_code = 4'h7;
            4'd7:    exp_code = 4'h5;
            4'd8:    exp_code = 4'h6;
            4'd9:    exp_code = 4'h4;
            4'd10:   exp_code = 4'h3;
            4'd11:   exp_code = 4'h7;
            4'd12:   exp_code = 4'h5;
            4'd13:   exp_code = 4'h8;
            default: exp_code = 4'hF;
        endcase
    end

    always_comb begin
        state_next     = state_reg;
        pos_next       = pos_reg;
        err_next       = err_reg;
        count_next     = count_reg;
        sym_valid_next = 1'b0;
        done_next      = 1'b0;
        code_next      = code_reg;
        match_next     = match_reg;
        if (stb_edge) begin
            sym_valid_next = 1'b1;
            code_next      = dec_code;
            match_next     = 1'b0;
            // Blanks are reported but never advance or disturb the sequence.
            if (dec_code != 4'h0) begin
                case (state_reg)
                    HUNT: begin
                        if (dec_code == 4'h1) begin
                            match_next = 1'b1;
                            pos_next   = 4'd1;
                            state_next = TRACK;
                        end
                    end
                    TRACK: begin
                        if (dec_code == exp_code) begin
                            match_next = 1'b1;
                            if (pos_reg == LAST_POS) begin
                                done_next  = 1'b1;
                                pos_next   = 4'd0;
                                state_next = HUNT;
                                if (count_reg != '1)
                                    count_next = count_reg + CNT_W'(1);
                            end else begin
                                pos_next = pos_reg + 4'd1;
                            end
                        end else begin
                            err_next = 1'b1;
                            if (dec_code == 4'h1) begin
                                pos_next = 4'd1;
                            end else begin
                                pos_next   = 4'd0;
                                state_next = HUNT;
                            end
                        end
                    end
                    default: state_next = HUNT;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= HUNT;
            pos_reg       <= 4'd0;
            err_reg       <= 1'b0;
            count_reg     <= '0;
            sym_valid_reg <= 1'b0;
            done_reg      <= 1'b0;
            code_reg      <= 4'h0;
            match_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            pos_reg       <= pos_next;
            err_reg       <= err_next;
            count_reg     <= count_next;
            sym_valid_reg <= sym_valid_next;
            done_reg      <= done_next;
            code_reg      <= code_next;
            match_reg     <= match_next;
        end
    end

    assign bus.sym_valid = sym_valid_reg;
    assign bus.sym_code  = code_reg;
    assign bus.match     = match_reg;
    assign bus.pos       = pos_reg;
    assign bus.msg_done  = done_reg;
    assign bus.err       = err_reg;
    assign bus.msg_count = count_reg;
endmodule
